// File: rtl/count_frame_scheduler.sv
// Purpose : snapshot/clear the channel counters on each second pulse and stream one frame to the UART.
// Latency : counters cleared one cycle after the pulse; first SYNC strobe four cycles after the pulse edge.
// Backpr. : a strobe is held while uart_busy_i=1; an unacknowledged byte is retried, then the frame aborts.
// Option  : define CHECKSUM_EN to append an XOR checksum byte to every frame.
module count_frame_scheduler #(
  parameter int         NCH     = 8,
  parameter int         CW      = 8,
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter int         ACK_TO  = 16,
  parameter int         MAX_RTY = 3
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_i,
  input  logic              sec_pulse_i,
  input  logic [NCH-1:0]    ch_mask_i,
  input  logic [NCH*CW-1:0] cnt_i,
  output logic              cnt_clr_o,
  input  logic              uart_busy_i,
  output logic              uart_wr_o,
  output logic [7:0]        uart_dat_o,
  output logic              frame_active_o,
  output logic [7:0]        overrun_o,
  output logic              tx_err_o
);

  localparam int HDR = (NCH > 8) ? 4 : 3;
  localparam int NB  = CW / 8;
  localparam int TW  = $clog2(ACK_TO + 1);
  localparam int RW  = (MAX_RTY < 1) ? 1 : $clog2(MAX_RTY + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SNAP, S_LOAD, S_STROBE, S_WAIT_ACK, S_WAIT_DONE
`ifdef CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [NCH*CW-1:0] r_cnt;
  logic [NCH-1:0]    r_mask;
  logic [7:0]        r_seq;
  logic [2:0]        r_hdr;      // header bytes already sent
  logic [4:0]        r_ch;       // lowest channel still eligible
  logic [4:0]        r_cur_ch;   // channel of the byte in flight
  logic              r_bsel;     // 0 = MSB byte of a 16-bit count
  logic [7:0]        r_byte;
  logic [7:0]        r_dat;
  logic              r_wr;
  logic [TW-1:0]     r_to;
  logic [RW-1:0]     r_rty;
  logic [7:0]        r_ovr;
  logic              r_err;
`ifdef CHECKSUM_EN
  logic [7:0]        r_csum;
  logic              r_csum_sent;
`endif

  logic        w_found;
  logic [4:0]  w_sel_ch;
  logic [15:0] w_word;
  logic [15:0] w_mask16;
  logic [7:0]  w_hdr_byte;
  logic [7:0]  w_load_byte;
  logic        w_load_ok;
  logic        w_take, w_strobe, w_ack, w_retry, w_abort, w_finish, w_advance;

  assign w_mask16 = 16'(r_mask);

  // find the lowest enabled channel at or above the current channel pointer
  always_comb begin
    w_found  = 1'b0;
    w_sel_ch = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (r_mask[i] && (i >= int'(r_ch))) begin
        w_found  = 1'b1;
        w_sel_ch = 5'(i);
      end
    end
  end

  // pick the snapshot word of the selected channel
  always_comb begin
    w_word = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_sel_ch == 5'(i)) w_word = 16'(r_cnt[i*CW +: CW]);
    end
  end

  // frame byte selection: header first, then counts MSB byte first
  always_comb begin
    case (r_hdr)
      3'd0:    w_hdr_byte = SYNC;
      3'd1:    w_hdr_byte = r_seq;
      3'd2:    w_hdr_byte = w_mask16[7:0];
      default: w_hdr_byte = w_mask16[15:8];
    endcase
    w_load_ok = (r_hdr < 3'(HDR)) || w_found;
    if (r_hdr < 3'(HDR))             w_load_byte = w_hdr_byte;
    else if ((NB == 2) && !r_bsel)   w_load_byte = w_word[15:8];
    else                             w_load_byte = w_word[7:0];
  end

  // state register
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  // next-state and control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_strobe    = 1'b0;
    w_ack       = 1'b0;
    w_retry     = 1'b0;
    w_abort     = 1'b0;
    w_finish    = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      S_IDLE:   if (sec_pulse_i) w_state_nxt = S_SNAP;
      S_SNAP:   w_state_nxt = S_LOAD;
      S_LOAD: begin
`ifdef CHECKSUM_EN
        if (r_csum_sent) begin
          w_finish    = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_load_ok) begin
          w_take      = 1'b1;
          w_state_nxt = S_STROBE;
        end else begin
          w_state_nxt = S_CSUM;
        end
`else
        if (w_load_ok) begin
          w_take      = 1'b1;
          w_state_nxt = S_STROBE;
        end else begin
          w_finish    = 1'b1;
          w_state_nxt = S_IDLE;
        end
`endif
      end
`ifdef CHECKSUM_EN
      S_CSUM:   w_state_nxt = S_STROBE;
`endif
      S_STROBE: begin
        if (!uart_busy_i) begin
          w_strobe    = 1'b1;
          w_state_nxt = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (uart_busy_i) begin
          w_ack       = 1'b1;
          w_state_nxt = S_WAIT_DONE;
        end else if (r_to == TW'(ACK_TO - 1)) begin
          if (r_rty >= RW'(MAX_RTY)) begin
            w_abort     = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_retry     = 1'b1;
            w_state_nxt = S_STROBE;
          end
        end
      end
      S_WAIT_DONE: begin
        if (!uart_busy_i) begin
          w_advance   = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // snapshot, frame pointer and byte-in-flight bookkeeping
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      r_cnt    <= '0;
      r_mask   <= '0;
      r_hdr    <= '0;
      r_ch     <= '0;
      r_cur_ch <= '0;
      r_bsel   <= 1'b0;
      r_byte   <= '0;
`ifdef CHECKSUM_EN
      r_csum      <= '0;
      r_csum_sent <= 1'b0;
`endif
    end else begin
      if (r_state == S_SNAP) begin
        r_cnt  <= cnt_i;
        r_mask <= ch_mask_i;
        r_hdr  <= '0;
        r_ch   <= '0;
        r_bsel <= 1'b0;
`ifdef CHECKSUM_EN
        r_csum      <= '0;
        r_csum_sent <= 1'b0;
`endif
      end
      if (w_take) begin
        r_byte   <= w_load_byte;
        r_cur_ch <= w_sel_ch;
`ifdef CHECKSUM_EN
        r_csum   <= r_csum ^ w_load_byte;
`endif
      end
`ifdef CHECKSUM_EN
      if (r_state == S_CSUM) begin
        r_byte      <= r_csum;
        r_csum_sent <= 1'b1;
      end
`endif
      if (w_advance) begin
        if (r_hdr < 3'(HDR)) begin
          r_hdr <= r_hdr + 3'd1;
        end else if ((NB == 2) && !r_bsel) begin
          r_bsel <= 1'b1;
        end else begin
          r_bsel <= 1'b0;
          r_ch   <= r_cur_ch + 5'd1;
        end
      end
    end
  end

  // UART strobe, ack timeout, retries, sequence number and error flags
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      r_wr  <= 1'b0;
      r_dat <= '0;
      r_to  <= '0;
      r_rty <= '0;
      r_seq <= '0;
      r_err <= 1'b0;
    end else begin
      r_wr <= w_strobe;
      if (w_strobe) begin
        r_dat <= r_byte;
        r_to  <= '0;
      end else if (r_state == S_WAIT_ACK) begin
        r_to <= r_to + TW'(1);
      end
      if (r_state == S_SNAP || w_ack) r_rty <= '0;
      else if (w_retry)               r_rty <= r_rty + RW'(1);
      if (w_abort)              r_err <= 1'b1;
      if (w_finish || w_abort)  r_seq <= r_seq + 8'd1;
    end
  end

  // count pulses that arrive while a frame is in progress, saturating
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i)
      r_ovr <= '0;
    else if (sec_pulse_i && (r_state != S_IDLE) && (r_ovr != 8'hFF))
      r_ovr <= r_ovr + 8'd1;
  end

  assign cnt_clr_o      = (r_state == S_SNAP);
  assign frame_active_o = (r_state != S_IDLE);
  assign uart_wr_o      = r_wr;
  assign uart_dat_o     = r_dat;
  assign overrun_o      = r_ovr;
  assign tx_err_o       = r_err;

endmodule

// File: tb/tb_count_frame_scheduler.sv
// Directed bench for count_frame_scheduler: one 8x8-bit instance, one 8x16-bit instance,
// each with a simple UART model that goes busy for 10 cycles after every accepted strobe.
module tb_count_frame_scheduler;
  localparam int ACK_TO  = 16;
  localparam int MAX_RTY = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         sec_a = 1'b0, sec_b = 1'b0;
  logic [7:0]   mask_a = '0, mask_b = '0;
  logic [63:0]  cnt_a = '0;
  logic [127:0] cnt_b = '0;
  logic         hold_a = 1'b0, ok_a = 1'b1;
  logic         clr_a, clr_b, busy_a, busy_b, wr_a, wr_b, act_a, act_b, err_a, err_b;
  logic [7:0]   dat_a, dat_b, ovr_a, ovr_b;

  count_frame_scheduler #(.NCH(8), .CW(8), .SYNC(8'hA5), .ACK_TO(ACK_TO), .MAX_RTY(MAX_RTY)) u_a (
    .sys_clk_i(clk), .sys_rst_i(rst), .sec_pulse_i(sec_a), .ch_mask_i(mask_a), .cnt_i(cnt_a),
    .cnt_clr_o(clr_a), .uart_busy_i(busy_a), .uart_wr_o(wr_a), .uart_dat_o(dat_a),
    .frame_active_o(act_a), .overrun_o(ovr_a), .tx_err_o(err_a));

  count_frame_scheduler #(.NCH(8), .CW(16), .SYNC(8'hA5), .ACK_TO(ACK_TO), .MAX_RTY(MAX_RTY)) u_b (
    .sys_clk_i(clk), .sys_rst_i(rst), .sec_pulse_i(sec_b), .ch_mask_i(mask_b), .cnt_i(cnt_b),
    .cnt_clr_o(clr_b), .uart_busy_i(busy_b), .uart_wr_o(wr_b), .uart_dat_o(dat_b),
    .frame_active_o(act_b), .overrun_o(ovr_b), .tx_err_o(err_b));

  // UART models
  int bcnt_a, bcnt_b;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt_a <= 0;
      bcnt_b <= 0;
    end else begin
      if (wr_a && ok_a)     bcnt_a <= 10;
      else if (bcnt_a != 0) bcnt_a <= bcnt_a - 1;
      if (wr_b)             bcnt_b <= 10;
      else if (bcnt_b != 0) bcnt_b <= bcnt_b - 1;
    end
  end
  assign busy_a = (bcnt_a != 0) || hold_a;
  assign busy_b = (bcnt_b != 0);

  // monitors: sampled on the falling edge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] q_a[$], q_b[$];
  int         wc_a[$], wc_b[$];
  int         nclr_a = 0, nclr_b = 0, dbl = 0;
  logic       pwr_a = 1'b0, pwr_b = 1'b0;
  always @(negedge clk) begin
    if (wr_a) begin q_a.push_back(dat_a); wc_a.push_back(cyc); end
    if (wr_b) begin q_b.push_back(dat_b); wc_b.push_back(cyc); end
    if (wr_a && pwr_a) dbl <= dbl + 1;
    if (wr_b && pwr_b) dbl <= dbl + 1;
    if (clr_a) nclr_a <= nclr_a + 1;
    if (clr_b) nclr_b <= nclr_b + 1;
    pwr_a <= wr_a;
    pwr_b <= wr_b;
  end

  int n_vec = 0, n_miss = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int               inst;
    logic [7:0]       mask;
    logic [127:0]     cnt;
    int               n;
    logic [0:10][7:0] e;
  } vec_t;

  function automatic vec_t mk(input int inst, input logic [7:0] m, input logic [127:0] c,
                              input int n, input logic [0:10][7:0] e);
    vec_t v;
    v.inst = inst; v.mask = m; v.cnt = c; v.n = n; v.e = e;
    return v;
  endfunction

  int bq, bclr, t_pulse;

  // pulse the selected instance and check the snapshot cycle
  task automatic start_vec(input vec_t v, input string tag);
    @(negedge clk);
    if (v.inst == 0) begin
      mask_a = v.mask; cnt_a = v.cnt[63:0]; bq = q_a.size(); bclr = nclr_a; sec_a = 1'b1;
    end else begin
      mask_b = v.mask; cnt_b = v.cnt; bq = q_b.size(); bclr = nclr_b; sec_b = 1'b1;
    end
    @(negedge clk);
    sec_a = 1'b0; sec_b = 1'b0; t_pulse = cyc;
    chk({tag, " active@snap"}, (v.inst == 0) ? act_a : act_b, 1);
    chk({tag, " clr@snap"},    (v.inst == 0) ? clr_a : clr_b, 1);
    @(negedge clk);
    chk({tag, " clr after snap"}, (v.inst == 0) ? clr_a : clr_b, 0);
  endtask

  // wait for frame end and compare the captured byte stream
  task automatic finish_vec(input vec_t v, input string tag);
    int k, got_n, d0;
    logic [7:0] ex[$];
    logic [7:0] x, g;
    k = 0;
    while (((v.inst == 0) ? act_a : act_b) && k < 3000) begin @(negedge clk); k++; end
    chk({tag, " frame ends"}, k < 3000, 1);
    x = 8'h00;
    for (int i = 0; i < v.n; i++) begin ex.push_back(v.e[i]); x = x ^ v.e[i]; end
`ifdef CHECKSUM_EN
    ex.push_back(x);
`endif
    got_n = (v.inst == 0) ? q_a.size() - bq : q_b.size() - bq;
    chk({tag, " byte count"}, got_n, ex.size());
    for (int i = 0; i < ex.size() && i < got_n; i++) begin
      g = (v.inst == 0) ? q_a[bq+i] : q_b[bq+i];
      chk($sformatf("%s byte%0d", tag, i), g, ex[i]);
    end
    chk({tag, " clear pulses"}, ((v.inst == 0) ? nclr_a : nclr_b) - bclr, 1);
    chk({tag, " back-to-back strobes"}, dbl, 0);
    if (got_n > 0) begin
      d0 = ((v.inst == 0) ? wc_a[bq] : wc_b[bq]) - t_pulse;
      chk($sformatf("%s first strobe latency %0d >= 3", tag, d0), d0 >= 3, 1);
    end
  endtask

  vec_t tbl [0:6];
  vec_t v;
  int   k, n, gap;

  initial begin
    tbl[0] = mk(0, 8'h03, 128'h9999_9999_9999_0703, 5, {8'hA5, 8'h00, 8'h03, 8'h03, 8'h07, 48'h0});
    tbl[1] = mk(0, 8'h00, 128'h0102_0304_0506_0708, 3, {8'hA5, 8'h01, 8'h00, 64'h0});
    tbl[2] = mk(0, 8'h81, 128'hFF22_2222_2222_2211, 5, {8'hA5, 8'h02, 8'h81, 8'h11, 8'hFF, 48'h0});
    tbl[3] = mk(0, 8'hFF, 128'h1716_1514_1312_1110, 11,
                {8'hA5, 8'h03, 8'hFF, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17});
    tbl[4] = mk(0, 8'h5A, 128'hEEDD_EECC_BBEE_AAEE, 7,
                {8'hA5, 8'h04, 8'h5A, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 32'h0});
    tbl[5] = mk(1, 8'h04, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_1234_FFFF_FFFF, 5,
                {8'hA5, 8'h00, 8'h04, 8'h12, 8'h34, 48'h0});
    tbl[6] = mk(1, 8'h81, 128'h0102_5555_5555_5555_5555_5555_5555_ABCD, 7,
                {8'hA5, 8'h01, 8'h81, 8'hAB, 8'hCD, 8'h01, 8'h02, 32'h0});

    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst wr", wr_a, 0);     chk("rst dat", dat_a, 0);  chk("rst active", act_a, 0);
    chk("rst clr", clr_a, 0);   chk("rst overrun", ovr_a, 0); chk("rst err", err_a, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // table-driven frames
    for (int i = 0; i < 7; i++) begin
      start_vec(tbl[i], $sformatf("tbl%0d", i));
      finish_vec(tbl[i], $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d err", i), (tbl[i].inst == 0) ? err_a : err_b, 0);
    end

    // busy held high: strobe waits, empty mask gives header only
    v = mk(0, 8'h00, 128'h55, 3, {8'hA5, 8'h05, 8'h00, 64'h0});
    hold_a = 1'b1;
    start_vec(v, "hold");
    repeat (30) @(negedge clk);
    chk("hold no strobe while busy", q_a.size() - bq, 0);
    chk("hold still active", act_a, 1);
    hold_a = 1'b0;
    finish_vec(v, "hold");

    // two pulses during a frame
    v = mk(0, 8'h03, 128'h9999_9999_9999_0703, 5, {8'hA5, 8'h06, 8'h03, 8'h03, 8'h07, 48'h0});
    start_vec(v, "ovr2");
    repeat (20) @(negedge clk);
    sec_a = 1'b1; @(negedge clk); sec_a = 1'b0;
    repeat (20) @(negedge clk);
    sec_a = 1'b1; @(negedge clk); sec_a = 1'b0;
    finish_vec(v, "ovr2");
    chk("overrun after 2 pulses", ovr_a, 2);

    // 300 consecutive pulses saturate the overrun count
    @(negedge clk); sec_a = 1'b1;
    repeat (300) @(negedge clk);
    sec_a = 1'b0;
    k = 0;
    while (act_a && k < 3000) begin @(negedge clk); k++; end
    chk("sat frame ends", k < 3000, 1);
    chk("overrun saturated", ovr_a, 255);

    // reset in the middle of a long frame
    start_vec(tbl[3], "midrst");
    repeat (30) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst wr", wr_a, 0);    chk("midrst dat", dat_a, 0);     chk("midrst active", act_a, 0);
    chk("midrst clr", clr_a, 0);  chk("midrst overrun", ovr_a, 0); chk("midrst err", err_a, 0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    start_vec(tbl[0], "postrst");
    finish_vec(tbl[0], "postrst");

    // UART never acknowledges: four strobes, abort, sticky error
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    ok_a = 1'b0;
    start_vec(tbl[0], "noack");
    k = 0;
    while (act_a && k < 500) begin @(negedge clk); k++; end
    chk("noack aborts", k < 500, 1);
    n = q_a.size() - bq;
    chk("noack strobe count", n, MAX_RTY + 1);
    for (int i = 0; i < n; i++) chk($sformatf("noack byte%0d", i), q_a[bq+i], 8'hA5);
    for (int i = 1; i < n; i++) begin
      gap = wc_a[bq+i] - wc_a[bq+i-1];
      chk($sformatf("noack gap%0d=%0d in [ACK_TO,ACK_TO+3]", i, gap), (gap >= ACK_TO) && (gap <= ACK_TO + 3), 1);
    end
    chk("noack err", err_a, 1);
    chk("noack inactive", act_a, 0);
    ok_a = 1'b1;
    repeat (3) @(negedge clk);
    v = mk(0, 8'h03, 128'h9999_9999_9999_0703, 5, {8'hA5, 8'h01, 8'h03, 8'h03, 8'h07, 48'h0});
    start_vec(v, "afterabort");
    finish_vec(v, "afterabort");
    chk("err sticky", err_a, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // global watchdog
  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end
endmodule
